// File: rtl/Noc_parameters.sv
// Shared NoC flit-format constants: field positions, marker values and ID widths.
// Every block that parses or builds flits takes its format from here.
package Noc_parameters;

  localparam int Noc_Data_Width   = 32;
  localparam int Noc_ID_X_Width   = 2;
  localparam int Noc_ID_Y_Width   = 2;

  // H marker [31:28], source ID [27:24], destination ID [23:20], E marker [19:16]
  localparam int Noc_Point_H      = 28;
  localparam int Noc_Source_Point = 24;
  localparam int Axi_Len_Point    = 20;
  localparam int Noc_Point_E      = 16;

  localparam logic [3:0] Noc_Head_H = 4'hA;
  localparam logic [3:0] Noc_Head_E = 4'h5;
  localparam logic [3:0] Noc_Tail_H = 4'hC;
  localparam logic [3:0] Noc_Tail_E = 4'h3;

endpackage

// File: rtl/noc_depacketizer_pkg.sv
// Types shared by the depacketizer, its interface and its payload FIFO.
// Holds types only; all flit-format numbers live in Noc_parameters.
package noc_depacketizer_pkg;
  import Noc_parameters::*;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_e;

  typedef struct packed {
    logic                      is_header;
    logic                      is_tail;
    logic [Noc_Data_Width-1:0] data;
  } flit_t;

  typedef struct packed {
    logic                      last;
    logic [Noc_Data_Width-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/noc_depacketizer_if.sv
// Flit input from the router local port and payload stream output of the depacketizer.
// slave is the depacketizer side, master is the router/consumer side.
interface noc_depacketizer_if;
  import Noc_parameters::*;
  import noc_depacketizer_pkg::*;

  logic                      in_valid;
  flit_t                     in_flit;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [Noc_Data_Width-1:0] out_data;
  logic                      out_last;

  modport slave (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/noc_flit_fifo.sv
// Show-ahead synchronous FIFO for payload words; head entry is visible on pop_data
// while not empty. Pushes into a full FIFO are dropped even if a pop happens that cycle.
module noc_flit_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             noc_clk,
  input  logic             noc_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge noc_clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/noc_depacketizer.sv
// Strips header/tail flits from NoC packets and streams payload words with a last marker.
// One data word is held back so the final word can be tagged last when the tail arrives.
module noc_depacketizer
  import Noc_parameters::*;
  import noc_depacketizer_pkg::*;
#(
  parameter logic [Noc_ID_X_Width-1:0] X_ID       = '0,
  parameter logic [Noc_ID_Y_Width-1:0] Y_ID       = '0,
  parameter int                        FIFO_DEPTH = 4
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  noc_depacketizer_if.slave         bus,
  output logic                      pkt_done,
  output logic [Noc_ID_X_Width-1:0] pkt_src_x,
  output logic [Noc_ID_Y_Width-1:0] pkt_src_y,
  output logic [7:0]                pkt_len,
  output logic                      err_misroute,
  output logic                      err_protocol,
  output logic [15:0]               pkt_count,
  output logic [15:0]               err_count
);
  localparam int IdW      = Noc_ID_X_Width + Noc_ID_Y_Width;
  localparam int DstPoint = Noc_Source_Point - IdW;
  localparam int HW       = Noc_Data_Width - Noc_Point_H;
  localparam int EW       = Axi_Len_Point - Noc_Point_E;

  flit_t                     flit;
  logic [HW-1:0]             h_mark;
  logic [EW-1:0]             e_mark;
  logic [IdW-1:0]            src_id, dst_id;
  logic                      head_ok, tail_ok, accept, start_pkt;

  state_e                    state_q, state_d;
  logic                      running_q, running_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [Noc_Data_Width-1:0] hold_data_q, hold_data_d;
  logic [Noc_ID_X_Width-1:0] cur_x_q, cur_x_d, pkt_src_x_q, pkt_src_x_d;
  logic [Noc_ID_Y_Width-1:0] cur_y_q, cur_y_d, pkt_src_y_q, pkt_src_y_d;
  logic [7:0]                len_q, len_d, pkt_len_q, pkt_len_d;
  logic                      pkt_done_q, pkt_done_d;
  logic                      err_mis_q, err_mis_d, err_proto_q, err_proto_d;
  logic [15:0]               pkt_count_q, pkt_count_d, err_count_q, err_count_d;

  logic                      fifo_push, fifo_full, fifo_empty;
  fifo_word_t                fifo_push_word, fifo_pop_word;

  assign flit    = bus.in_flit;
  assign h_mark  = flit.data[Noc_Data_Width-1:Noc_Point_H];
  assign e_mark  = flit.data[Axi_Len_Point-1:Noc_Point_E];
  assign src_id  = flit.data[Noc_Point_H-1:Noc_Source_Point];
  assign dst_id  = flit.data[Noc_Source_Point-1:DstPoint];
  assign head_ok = flit.is_header && !flit.is_tail && (h_mark == Noc_Head_H) && (e_mark == Noc_Head_E);
  assign tail_ok = (h_mark == Noc_Tail_H) && (e_mark == Noc_Tail_E);

  // running_q keeps in_ready low during reset and its release cycle without touching the reset pin.
  assign bus.in_ready = running_q && (!hold_valid_q || !fifo_full);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d        = state_q;
    running_d      = 1'b1;
    hold_valid_d   = hold_valid_q;
    hold_data_d    = hold_data_q;
    cur_x_d        = cur_x_q;
    cur_y_d        = cur_y_q;
    len_d          = len_q;
    pkt_src_x_d    = pkt_src_x_q;
    pkt_src_y_d    = pkt_src_y_q;
    pkt_len_d      = pkt_len_q;
    pkt_done_d     = 1'b0;
    err_mis_d      = 1'b0;
    err_proto_d    = 1'b0;
    pkt_count_d    = pkt_count_q;
    err_count_d    = err_count_q;
    fifo_push      = 1'b0;
    fifo_push_word = '{last: 1'b1, data: hold_data_q};
    start_pkt      = 1'b0;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (head_ok) start_pkt = 1'b1;
          else         err_proto_d = 1'b1;
        end
        BODY: begin
          if (flit.is_header) begin
            // Header without a tail closes the open packet unannounced and may open a new one.
            fifo_push    = hold_valid_q;
            hold_valid_d = 1'b0;
            err_proto_d  = 1'b1;
            state_d      = IDLE;
            start_pkt    = head_ok;
          end else if (flit.is_tail) begin
            fifo_push    = hold_valid_q;
            hold_valid_d = 1'b0;
            pkt_done_d   = 1'b1;
            pkt_src_x_d  = cur_x_q;
            pkt_src_y_d  = cur_y_q;
            pkt_len_d    = len_q;
            pkt_count_d  = pkt_count_q + 16'd1;
            err_proto_d  = !tail_ok;
            state_d      = IDLE;
          end else begin
            fifo_push           = hold_valid_q;
            fifo_push_word.last = 1'b0;
            hold_valid_d        = 1'b1;
            hold_data_d         = flit.data;
            if (len_q != 8'hFF) len_d = len_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start_pkt) begin
      state_d      = BODY;
      hold_valid_d = 1'b0;
      len_d        = 8'd0;
      cur_x_d      = src_id[IdW-1:Noc_ID_Y_Width];
      cur_y_d      = src_id[Noc_ID_Y_Width-1:0];
      err_mis_d    = (dst_id != {X_ID, Y_ID});
    end

    if ((err_mis_d || err_proto_d) && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q      <= IDLE;
      running_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      len_q        <= '0;
      pkt_src_x_q  <= '0;
      pkt_src_y_q  <= '0;
      pkt_len_q    <= '0;
      pkt_done_q   <= 1'b0;
      err_mis_q    <= 1'b0;
      err_proto_q  <= 1'b0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      running_q    <= running_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      len_q        <= len_d;
      pkt_src_x_q  <= pkt_src_x_d;
      pkt_src_y_q  <= pkt_src_y_d;
      pkt_len_q    <= pkt_len_d;
      pkt_done_q   <= pkt_done_d;
      err_mis_q    <= err_mis_d;
      err_proto_q  <= err_proto_d;
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
    end
  end

  noc_flit_fifo #(
    .WIDTH (Noc_Data_Width + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .push      (fifo_push),
    .push_data (fifo_push_word),
    .pop       (bus.out_ready),
    .pop_data  (fifo_pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_pop_word.data;
  assign bus.out_last  = fifo_pop_word.last;
  assign pkt_done      = pkt_done_q;
  assign pkt_src_x     = pkt_src_x_q;
  assign pkt_src_y     = pkt_src_y_q;
  assign pkt_len       = pkt_len_q;
  assign err_misroute  = err_mis_q;
  assign err_protocol  = err_proto_q;
  assign pkt_count     = pkt_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_noc_depacketizer.sv
// Self-checking bench: a table of flits with hand-written expected pulses/outputs,
// plus backpressure and mid-packet reset sequences; payload words checked via a queue.
module tb_noc_depacketizer;
  import Noc_parameters::*;
  import noc_depacketizer_pkg::*;

  localparam logic I = 1'b1;
  localparam logic O = 1'b0;
  // Headers: {H, src(x,y), dst(x,y), E, 16'h0}; node under test is (0,0).
  localparam logic [31:0] HDR21   = 32'hA905_0000;  // src (2,1) -> (0,0)
  localparam logic [31:0] HDR13   = 32'hA705_0000;  // src (1,3) -> (0,0)
  localparam logic [31:0] HDR_MIS = 32'hA945_0000;  // src (2,1) -> (1,0)
  localparam logic [31:0] HDR_BAD = 32'hB905_0000;  // wrong H marker
  localparam logic [31:0] TAIL    = 32'hC003_0000;
  localparam logic [31:0] TAIL_BD = 32'hC000_0000;  // wrong E marker
  localparam logic [31:0] Z       = 32'h0;

  typedef struct {
    logic h; logic t; logic [31:0] d;
    logic done; logic mis; logic proto;
    logic emit; logic last; logic [31:0] word;
    logic [7:0] len; logic [1:0] sx; logic [1:0] sy;
  } vec_t;

  logic noc_clk, noc_rst_n;
  logic pkt_done, err_misroute, err_protocol;
  logic [1:0]  pkt_src_x, pkt_src_y;
  logic [7:0]  pkt_len;
  logic [15:0] pkt_count, err_count;

  noc_depacketizer_if bus ();

  noc_depacketizer #(.X_ID(2'd0), .Y_ID(2'd0), .FIFO_DEPTH(4)) dut (
    .noc_clk      (noc_clk),
    .noc_rst_n    (noc_rst_n),
    .bus          (bus),
    .pkt_done     (pkt_done),
    .pkt_src_x    (pkt_src_x),
    .pkt_src_y    (pkt_src_y),
    .pkt_len      (pkt_len),
    .err_misroute (err_misroute),
    .err_protocol (err_protocol),
    .pkt_count    (pkt_count),
    .err_count    (err_count)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  int         n_cmp = 0, n_bad = 0;
  int         done_seen = 0, exp_done_total = 0;
  int         exp_err = 0, exp_pkts = 0;
  fifo_word_t exp_q[$];
  vec_t       v[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic h, input logic t, input logic [31:0] d,
                              input logic done, input logic mis, input logic proto,
                              input logic emit, input logic last, input logic [31:0] word,
                              input logic [7:0] len, input logic [1:0] sx, input logic [1:0] sy);
    vec_t r;
    r = '{h, t, d, done, mis, proto, emit, last, word, len, sx, sy};
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following acceptance (or after the bound).
  task automatic send(input logic h, input logic t, input logic [31:0] d, output bit ok);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_flit  = {h, t, d};
    while (!bus.in_ready && n < 200) begin
      @(negedge noc_clk);
      n++;
    end
    ok = bus.in_ready;
    if (ok) @(posedge noc_clk);
    @(negedge noc_clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic apply(input vec_t x, input string tag);
    bit ok;
    if (x.emit) exp_q.push_back({x.last, x.word});
    send(x.h, x.t, x.d, ok);
    if (x.done) exp_done_total++;
    if (x.done) exp_pkts++;
    if (x.mis || x.proto) exp_err++;
    check({tag, "_accepted"}, 32'(ok), 32'(1'b1));
    check({tag, "_pkt_done"}, 32'(pkt_done), 32'(x.done));
    check({tag, "_err_misroute"}, 32'(err_misroute), 32'(x.mis));
    check({tag, "_err_protocol"}, 32'(err_protocol), 32'(x.proto));
    check({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    if (x.done) begin
      check({tag, "_pkt_len"}, 32'(pkt_len), 32'(x.len));
      check({tag, "_pkt_src_x"}, 32'(pkt_src_x), 32'(x.sx));
      check({tag, "_pkt_src_y"}, 32'(pkt_src_y), 32'(x.sy));
    end
    $display("txn %s: flit h=%0b t=%0b d=%h done=%0b mis=%0b proto=%0b len=%0d",
             tag, x.h, x.t, x.d, pkt_done, err_misroute, err_protocol, pkt_len);
  endtask

  // Output monitor: handshake state is stable from just after the negedge to the next posedge.
  initial begin : monitor
    fifo_word_t e;
    forever begin
      @(negedge noc_clk);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got word %h last=%0b, expected none", bus.out_data, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_last", 32'(bus.out_last), 32'(e.last));
          $display("txn out: data=%h last=%0b", bus.out_data, bus.out_last);
        end
      end
    end
  end

  initial begin : pulse_count
    forever begin
      @(negedge noc_clk);
      if (pkt_done === 1'b1) done_seen++;
    end
  end

  initial begin : main
    bit ok;
    int done_before;
    int n;

    //           h  t  d        done mis proto emit last word          len   sx    sy
    v[0]  = mk(I, O, HDR21,   O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[1]  = mk(O, O, 32'hA5,  O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[2]  = mk(O, O, 32'h3C,  O, O, O, I, O, 32'hA5,       8'd0, 2'd0, 2'd0);
    v[3]  = mk(O, I, TAIL,    I, O, O, I, I, 32'h3C,       8'd2, 2'd2, 2'd1);
    v[4]  = mk(I, O, HDR13,   O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[5]  = mk(O, I, TAIL,    I, O, O, O, O, Z,            8'd0, 2'd1, 2'd3);
    v[6]  = mk(I, O, HDR_MIS, O, I, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[7]  = mk(O, O, 32'h11,  O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[8]  = mk(O, I, TAIL,    I, O, O, I, I, 32'h11,       8'd1, 2'd2, 2'd1);
    v[9]  = mk(O, O, 32'h22,  O, O, I, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[10] = mk(I, O, HDR_BAD, O, O, I, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[11] = mk(I, I, HDR21,   O, O, I, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[12] = mk(I, O, HDR21,   O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[13] = mk(O, O, 32'h33,  O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[14] = mk(O, I, TAIL_BD, I, O, I, I, I, 32'h33,       8'd1, 2'd2, 2'd1);
    v[15] = mk(I, O, HDR21,   O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[16] = mk(O, O, 32'h44,  O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[17] = mk(I, O, HDR13,   O, O, I, I, I, 32'h44,       8'd0, 2'd0, 2'd0);
    v[18] = mk(O, O, 32'h55,  O, O, O, O, O, Z,            8'd0, 2'd0, 2'd0);
    v[19] = mk(O, I, TAIL,    I, O, O, I, I, 32'h55,       8'd1, 2'd1, 2'd3);

    noc_rst_n     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_flit   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge noc_clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(1'b0));
    check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    check("rst_pkt_done", 32'(pkt_done), 32'(1'b0));
    check("rst_errors", 32'({err_misroute, err_protocol}), 32'(2'b00));
    check("rst_counts", {pkt_count, err_count}, 32'h0);
    check("rst_pkt_len", 32'(pkt_len), 32'h0);
    noc_rst_n = 1'b1;
    @(negedge noc_clk);

    for (int i = 0; i < 20; i++) begin
      apply(v[i], $sformatf("v%0d", i));
      repeat (2) @(negedge noc_clk);
    end

    // Backpressure: hold word + 4 FIFO entries absorb 5 data flits, the 6th must stall.
    bus.out_ready = 1'b0;
    apply(mk(I, O, HDR13, O, O, O, O, O, Z, 8'd0, 2'd0, 2'd0), "bp_hdr");
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) check($sformatf("bp_in_ready_before_%0d", k), 32'(bus.in_ready), 32'(1'b1));
      if (k == 6) begin
        check("bp_in_ready_low", 32'(bus.in_ready), 32'(1'b0));
        check("bp_out_valid", 32'(bus.out_valid), 32'(1'b1));
        bus.out_ready = 1'b1;
      end
      apply(mk(O, O, 32'h100 + 32'(k), O, O, O, (k > 1), O, 32'h100 + 32'(k - 1),
               8'd0, 2'd0, 2'd0), $sformatf("bp_d%0d", k));
    end
    apply(mk(O, I, TAIL, I, O, O, I, I, 32'h106, 8'd6, 2'd1, 2'd3), "bp_tail");
    repeat (8) @(negedge noc_clk);

    // Reset in the middle of a packet: hold word and FIFO content are discarded.
    bus.out_ready = 1'b0;
    send(I, O, HDR21, ok);
    send(O, O, 32'h201, ok);
    send(O, O, 32'h202, ok);
    check("rr_pre_out_valid", 32'(bus.out_valid), 32'(1'b1));
    done_before = done_seen;
    noc_rst_n = 1'b0;
    #1;
    check("rr_out_valid", 32'(bus.out_valid), 32'(1'b0));
    check("rr_in_ready", 32'(bus.in_ready), 32'(1'b0));
    check("rr_counts", {pkt_count, err_count}, 32'h0);
    repeat (2) @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(negedge noc_clk);
    check("rr_no_pkt_done", 32'(done_seen), 32'(done_before));
    check("rr_out_valid_after", 32'(bus.out_valid), 32'(1'b0));
    exp_err  = 0;
    exp_pkts = 0;
    bus.out_ready = 1'b1;
    apply(mk(I, O, HDR13,   O, O, O, O, O, Z,       8'd0, 2'd0, 2'd0), "rr_hdr");
    apply(mk(O, O, 32'h66,  O, O, O, O, O, Z,       8'd0, 2'd0, 2'd0), "rr_d1");
    apply(mk(O, O, 32'h77,  O, O, O, I, O, 32'h66,  8'd0, 2'd0, 2'd0), "rr_d2");
    apply(mk(O, I, TAIL,    I, O, O, I, I, 32'h77,  8'd2, 2'd1, 2'd3), "rr_tail");

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge noc_clk);
      n++;
    end
    repeat (3) @(negedge noc_clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    check("final_pkt_done_total", 32'(done_seen), 32'(exp_done_total));
    check("final_out_valid", 32'(bus.out_valid), 32'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_depacketizer.md
NOC_DEPACKETIZER -- requirements
Module: noc_depacketizer

Interface
REQ-001 SHALL have parameter X_ID, default 0: own node X coordinate, Noc_ID_X_Width bits.
REQ-002 SHALL have parameter Y_ID, default 0: own node Y coordinate, Noc_ID_Y_Width bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: payload FIFO entries; power of two, at least 2.
REQ-004 SHALL have port noc_clk  in  1  clock.
REQ-005 SHALL have port noc_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  flit valid from the router local port, single VC.
REQ-007 SHALL have port in_flit  in  Noc_Data_Width+2  flit as {is_header, is_tail, data}.
REQ-008 SHALL have port in_ready  out  1  flit accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port out_valid / out_ready  out / in  1 / 1  payload stream handshake.
REQ-010 SHALL have port out_data  out  Noc_Data_Width  payload word.
REQ-011 SHALL have port out_last  out  1  marks the final payload word of a packet.
REQ-012 SHALL have port pkt_done  out  1  one-cycle pulse at packet end.
REQ-013 SHALL have port pkt_src_x / pkt_src_y  out  Noc_ID_X_Width / Noc_ID_Y_Width  source of the last completed packet.
REQ-014 SHALL have port pkt_len  out  8  data-flit count of the last completed packet; saturates at 255.
REQ-015 SHALL have port err_misroute / err_protocol  out  1 / 1  one-cycle error pulses.
REQ-016 SHALL have port pkt_count / err_count  out  16 / 16  packets completed (wraps) / errors (saturates at 65535).

Function
REQ-017 SHALL decode fields as follows: head/tail H marker = data[Noc_Data_Width-1:Noc_Point_H]; E marker = data[Axi_Len_Point-1:Noc_Point_E]; source ID = data[Noc_Point_H-1:Noc_Source_Point] with X high, Y low; destination ID follows immediately below the source ID.
REQ-018 SHALL implement an FSM with states IDLE and BODY; reset state IDLE.
REQ-019 SHALL, in IDLE, on acceptance of a flit with is_header=1, is_tail=0 and matching Noc_Head_H/Noc_Head_E markers: latch source, clear the length counter, go to BODY.
REQ-020 SHALL pulse err_misroute the cycle after a header is accepted whose destination differs from {X_ID, Y_ID}; the packet is still processed.
REQ-021 SHALL, in IDLE, drop any non-header flit, header with bad markers, or flit with both is_header and is_tail set, pulse err_protocol, and stay in IDLE.
REQ-022 SHALL hold the most recent data flit in a one-word hold register; on each further data flit, push the held word with last=0 into the FIFO and load the new word.
REQ-023 SHALL, on an accepted tail flit in BODY: push the held word (if any) with last=1, pulse pkt_done the next cycle, update pkt_src_x/pkt_src_y/pkt_len, increment pkt_count, and return to IDLE.
REQ-024 SHALL, on a tail with Noc_Tail_H/Noc_Tail_E mismatch, still end the packet per REQ-023 and also pulse err_protocol.
REQ-025 SHALL handle zero-data packets (header then tail): no FIFO push, pkt_done with pkt_len=0.
REQ-026 SHALL, on a header received in BODY: push the held word with last=1, pulse err_protocol, suppress pkt_done, and start the new packet per REQ-019.
REQ-027 SHALL drive in_ready = !hold_valid or !fifo_full, from registered state only (never from in_valid or out_ready).
REQ-028 SHALL block a push to a full FIFO even when a pop occurs in the same cycle.
REQ-029 SHALL drive out_valid = FIFO non-empty; a pushed word SHALL be visible on out_* at the earliest one cycle after the push.
REQ-030 SHALL keep out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-031 SHALL increment err_count once per cycle in which err_misroute or err_protocol pulses, even if both pulse together.

Reset
REQ-032 SHALL, while noc_rst_n=0, force in_ready=0, out_valid=0, pkt_done=0, all error pulses 0, all counters and registers 0, FSM in IDLE.
REQ-033 SHALL, on reset mid-packet, discard the hold word and FIFO contents with no pkt_done.

Structure
REQ-034 SHALL take flit-format constants (marker values, field points, widths) from Noc_parameters; no new package constants SHALL be added.
REQ-035 SHALL contain one sub-module, noc_flit_fifo (synchronous FIFO, width Noc_Data_Width+1, depth FIFO_DEPTH, full/empty outputs).

Verification
REQ-036 SHALL cover: header, data 0xA5, data 0x3C, tail, out_ready=1 -> out emits 0xA5 (last=0) then 0x3C (last=1); pkt_done once; pkt_len=2.
REQ-037 SHALL cover: header then tail -> no out_valid; pkt_done with pkt_len=0; pkt_count=1.
REQ-038 SHALL cover: header destined to (X_ID+1, Y_ID) -> err_misroute pulse; payload is still delivered; err_count=1.
REQ-039 SHALL cover: out_ready=0 with a 6-data-flit packet and FIFO_DEPTH=4 -> in_ready falls after 5 data flits accepted; no data loss after out_ready=1.
REQ-040 SHALL cover: header, data, header, data, tail -> first word has last=1; err_protocol pulses; exactly one pkt_done.
REQ-041 SHALL cover: reset asserted after 2 data flits -> out_valid=0; the next valid packet is received cleanly.
